dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_sram_array.sv | 33 +++
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types, constants and address checking for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;

  // A word access must be aligned and fall inside the 2**addr_width byte storage.
  function automatic logic is_bad_addr(input logic [31:0] addr, input int addr_width);
    logic [32:0] limit;
    limit = 33'd1 << addr_width;
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [WORD_BYTES-1:0] req_be;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_sram_array.sv
// Word-organised storage with per-byte-lane synchronous write and combinational read.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_WIDTH-3:0] widx,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-3:0] ridx,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  logic [31:0] mem [DEPTH];

  // No reset: storage contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem[widx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder FSM: accepts one request, waits LATENCY cycles, performs the access, returns a response.
// Optional macro DMEM_BACK_TO_BACK_EN lets a new request be accepted during the response handshake cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  dmem_state_t           state;
  dmem_state_t           state_next;
  logic [3:0]            counter;
  logic                  accept;
  logic                  access;
  logic                  bad;
  logic                  sram_we;
  logic                  cap_write;
  logic [31:0]           cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [WORD_BYTES-1:0] cap_be;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [31:0]           sram_rdata;

  assign bad     = is_bad_addr(cap_addr, ADDR_WIDTH);
  assign sram_we = access && cap_write && !bad && !reset;

  dmem_sram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .be    (cap_be),
    .widx  (cap_addr[ADDR_WIDTH-1:2]),
    .wdata (cap_wdata),
    .ridx  (cap_addr[ADDR_WIDTH-1:2]),
    .rdata (sram_rdata)
  );

  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    access         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = !reset;
        accept        = bus.req_valid && !reset;
        if (accept) state_next = WAIT;
      end
      WAIT: begin
        if (counter == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = !reset;
`ifdef DMEM_BACK_TO_BACK_EN
        bus.req_ready = bus.resp_ready && !reset;
        accept        = bus.req_valid && bus.resp_ready && !reset;
`endif
        if (bus.resp_ready) state_next = accept ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture registers are left alone on reset; only control and response state is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cap_write <= bus.req_write;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cap_be    <= bus.req_be;
        counter   <= 4'(LATENCY - 1);
      end else if (state == WAIT && counter != 4'd0) begin
        counter <= counter - 4'd1;
      end
      if (access) begin
        err_q   <= bad;
        rdata_q <= (bad || cap_write) ? '0 : sram_rdata;
      end
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int LAT = 2;
  localparam int AW  = 10;
`ifdef DMEM_BACK_TO_BACK_EN
  localparam int SPACING = LAT + 1;
`else
  localparam int SPACING = LAT + 2;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  dmem_responder_if bus ();

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  int          ncount  = 0;
  int          rr_mode = 1;
  logic [31:0] ref_mem [256];
  exp_t        sb [$];
  logic        busy = 1'b0;
  logic        hs_pending = 1'b0;
  exp_t        cur;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic failEvent(input string name);
    n_total++;
    $display("[TB] FAIL %s: got timeout/unexpected expected normal handshake", name);
  endtask

  // Reference model: plain byte-lane arithmetic over a word array.
  task automatic modelAccess(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] er, output logic ee);
    int idx;
    er = 32'h0;
    ee = 1'b0;
    if ((a % 4) != 0 || a >= 32'd1024) begin
      ee = 1'b1;
    end else begin
      idx = int'(a / 4);
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
      end else begin
        er = ref_mem[idx];
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be, input logic commit, output int acc);
    exp_t e;
    bit   done = 0;
    acc = -1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    for (int t = 0; t < 60 && !done; t++) begin
      #1;
      if (bus.req_ready) begin
        acc = ncount;
        done = 1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      failEvent("req_accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    if (commit) begin
      modelAccess(w, a, wd, be, e.rdata, e.err);
      e.acc = acc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && !busy && !hs_pending && !bus.resp_valid) ok = 1;
    end
    if (!ok) failEvent("drain_timeout");
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    case (rr_mode)
      0:       bus.resp_ready = ($urandom_range(0, 9) < 7);
      1:       bus.resp_ready = 1'b1;
      default: bus.resp_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on each new response, then checks hold-stability and release.
  initial begin
    forever begin
      @(negedge clk);
      ncount++;
      #2;
      if (hs_pending) begin
        checkOutput("resp_valid_after_hs", 32'(bus.resp_valid), 32'h0);
        hs_pending = 1'b0;
      end else if (bus.resp_valid) begin
        if (!busy) begin
          if (sb.size() == 0) begin
            failEvent("unexpected_resp");
          end else begin
            cur = sb.pop_front();
            busy = 1'b1;
            checkOutput("resp_rdata", bus.resp_rdata, cur.rdata);
            checkOutput("resp_err", 32'(bus.resp_err), 32'(cur.err));
            checkOutput("resp_latency", 32'(ncount - cur.acc), 32'(LAT + 1));
          end
        end else begin
          checkOutput("held_rdata", bus.resp_rdata, cur.rdata);
          checkOutput("held_err", 32'(bus.resp_err), 32'(cur.err));
        end
        if (!bus.resp_ready) checkOutput("req_ready_while_held", 32'(bus.req_ready), 32'h0);
        else begin
          hs_pending = 1'b1;
          busy = 1'b0;
        end
      end else if (busy) begin
        failEvent("resp_valid_dropped");
        busy = 1'b0;
      end
    end
  end

  initial begin
    int          acc;
    int          accs [4];
    logic        w;
    logic [31:0] a;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    checkOutput("rst_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst_err", 32'(bus.resp_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);

    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1, acc);
    waitIdle();

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, acc);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc);
    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, acc);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, acc);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, acc);
    applyStimulus(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 1'b1, acc);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, acc);
    applyStimulus(1'b0, 32'h400, 32'h0, 4'hF, 1'b1, acc);
    applyStimulus(1'b1, 32'h40, 32'h12345678, 4'h0, 1'b1, acc);
    applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, acc);
    waitIdle();

    rr_mode = 2;
    @(negedge clk);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc);
    repeat (LAT + 5) @(negedge clk);
    rr_mode = 1;
    waitIdle();

    applyStimulus(1'b1, 32'h30, 32'h00000055, 4'hF, 1'b0, acc);
    reset = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("midrst_resp_valid", 32'(bus.resp_valid), 32'h0);
    checkOutput("midrst_rdata", bus.resp_rdata, 32'h0);
    checkOutput("midrst_err", 32'(bus.resp_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_ready_after", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 1'b1, acc);
    waitIdle();

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'(16 * i), 32'h0, 4'hF, 1'b1, accs[i]);
    for (int i = 1; i < 4; i++) checkOutput("b2b_spacing", 32'(accs[i] - accs[i-1]), 32'(SPACING));
    waitIdle();

    rr_mode = 0;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'h400 + 32'($urandom_range(0, 255) * 4);
        2:       a = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
        default: a = 32'($urandom_range(0, 255) * 4);
      endcase
      applyStimulus(w, a, $urandom, 4'($urandom_range(0, 15)), 1'b1, acc);
    end
    rr_mode = 1;
    waitIdle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
